// File: rtl/baccarat_sequencer.sv
// Baccarat game controller: deals the four opening cards, applies the
// player and banker third-card rules to the datapath feedback, and
// reports the winner once the hand is complete.
module baccarat_sequencer (
   input  logic       slow_clock,
   input  logic       resetb,
   input  logic [3:0] pscore,
   input  logic [3:0] dscore,
   input  logic [3:0] pcard3,
   output logic       load_pcard1,
   output logic       load_pcard2,
   output logic       load_pcard3,
   output logic       load_dcard1,
   output logic       load_dcard2,
   output logic       load_dcard3,
   output logic       player_win_light,
   output logic       dealer_win_light,
   output logic       hand_done
);

   localparam logic [3:0] DEAL_P1   = 4'd0;
   localparam logic [3:0] DEAL_D1   = 4'd1;
   localparam logic [3:0] DEAL_P2   = 4'd2;
   localparam logic [3:0] DEAL_D2   = 4'd3;
   localparam logic [3:0] EVAL      = 4'd4;
   localparam logic [3:0] DRAW_P3   = 4'd5;
   localparam logic [3:0] BANK_EVAL = 4'd6;
   localparam logic [3:0] DRAW_D3   = 4'd7;
   localparam logic [3:0] RESULT    = 4'd8;

   logic [3:0] r_state;
   logic [3:0] w_next;
   logic [3:0] w_v;
   logic       w_natural;
   logic       w_bankDraw;

   // Face cards and tens count zero toward the banker decision.
   assign w_v       = ((pcard3 >= 4'd1) && (pcard3 <= 4'd9)) ? pcard3 : 4'd0;
   assign w_natural = (pscore >= 4'd8) || (dscore >= 4'd8);

   // Banker third-card table; an out-of-range banker score stands like a 7.
   always_comb begin
      w_bankDraw = 1'b0;
      case (dscore)
         4'd0, 4'd1, 4'd2: w_bankDraw = 1'b1;
         4'd3:             w_bankDraw = (w_v != 4'd8);
         4'd4:             w_bankDraw = (w_v >= 4'd2) && (w_v <= 4'd7);
         4'd5:             w_bankDraw = (w_v >= 4'd4) && (w_v <= 4'd7);
         4'd6:             w_bankDraw = (w_v >= 4'd6) && (w_v <= 4'd7);
         default:          w_bankDraw = 1'b0;
      endcase
   end

   // Next-state logic; unused encodings fall back to the start of a hand.
   always_comb begin
      w_next = DEAL_P1;
      case (r_state)
         DEAL_P1:   w_next = DEAL_D1;
         DEAL_D1:   w_next = DEAL_P2;
         DEAL_P2:   w_next = DEAL_D2;
         DEAL_D2:   w_next = EVAL;
         EVAL: begin
            if (w_natural)
               w_next = RESULT;
            else if (pscore <= 4'd5)
               w_next = DRAW_P3;
            else if (dscore <= 4'd5)
               w_next = DRAW_D3;
            else
               w_next = RESULT;
         end
         DRAW_P3:   w_next = BANK_EVAL;
         BANK_EVAL: w_next = w_bankDraw ? DRAW_D3 : RESULT;
         DRAW_D3:   w_next = RESULT;
         RESULT:    w_next = RESULT;
         default:   w_next = DEAL_P1;
      endcase
   end

   // State register; reset aborts any hand in progress immediately.
   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb)
         r_state <= DEAL_P1;
      else
         r_state <= w_next;
   end

   assign load_pcard1 = (r_state == DEAL_P1);
   assign load_dcard1 = (r_state == DEAL_D1);
   assign load_pcard2 = (r_state == DEAL_P2);
   assign load_dcard2 = (r_state == DEAL_D2);
   assign load_pcard3 = (r_state == DRAW_P3);
   assign load_dcard3 = (r_state == DRAW_D3);

   assign hand_done        = (r_state == RESULT);
   assign player_win_light = hand_done && (pscore >= dscore);
   assign dealer_win_light = hand_done && (dscore >= pscore);

endmodule

// File: tb/tb_baccarat_sequencer.sv
// Self-checking bench for baccarat_sequencer: a mock datapath drives the
// scores, a hand-level model predicts the strobe sequence and result, and
// one comparator checks every outputs on every falling clock edge.
module tb_baccarat_sequencer;

   localparam logic [5:0] S_P1 = 6'b000001;
   localparam logic [5:0] S_P2 = 6'b000010;
   localparam logic [5:0] S_P3 = 6'b000100;
   localparam logic [5:0] S_D1 = 6'b001000;
   localparam logic [5:0] S_D2 = 6'b010000;
   localparam logic [5:0] S_D3 = 6'b100000;
   localparam logic [6:0] E_RES = 7'h40;

   logic       slow_clock = 1'b0;
   logic       resetb     = 1'b0;
   logic [3:0] pscore     = 4'd0;
   logic [3:0] dscore     = 4'd0;
   logic [3:0] pcard3     = 4'd0;
   logic       load_pcard1, load_pcard2, load_pcard3;
   logic       load_dcard1, load_dcard2, load_dcard3;
   logic       player_win_light, dealer_win_light, hand_done;

   int         nChecks = 0;
   int         nErrors = 0;
   logic       checkEn = 1'b0;
   logic [5:0] expStrobe = S_P1;
   logic       expDone = 1'b0;
   logic       expPWin = 1'b0;
   logic       expDWin = 1'b0;

   logic [6:0] seq[$];
   logic [9:0] bankRow[10];

   baccarat_sequencer dut (
      .slow_clock       (slow_clock),
      .resetb           (resetb),
      .pscore           (pscore),
      .dscore           (dscore),
      .pcard3           (pcard3),
      .load_pcard1      (load_pcard1),
      .load_pcard2      (load_pcard2),
      .load_pcard3      (load_pcard3),
      .load_dcard1      (load_dcard1),
      .load_dcard2      (load_dcard2),
      .load_dcard3      (load_dcard3),
      .player_win_light (player_win_light),
      .dealer_win_light (dealer_win_light),
      .hand_done        (hand_done)
   );

   // Free-running game clock.
   always #5 slow_clock = ~slow_clock;

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Banker draw table as bitmasks over the third-card value 0..9.
   function automatic logic bankerDraws(input int ds, input int pc3);
      int v;
      v = (pc3 >= 1 && pc3 <= 9) ? pc3 : 0;
      return bankRow[ds][v];
   endfunction

   // Expected per-cycle strobes after reset release; E_RES marks the result.
   task automatic buildSeq(input int ps, input int ds, input int pc3);
      seq = {};
      seq.push_back({1'b0, S_P1});
      seq.push_back({1'b0, S_D1});
      seq.push_back({1'b0, S_P2});
      seq.push_back({1'b0, S_D2});
      seq.push_back(7'h00);
      if (ps >= 8 || ds >= 8) begin
         seq.push_back(E_RES);
      end else if (ps <= 5) begin
         seq.push_back({1'b0, S_P3});
         seq.push_back(7'h00);
         if (bankerDraws(ds, pc3)) seq.push_back({1'b0, S_D3});
         seq.push_back(E_RES);
      end else begin
         if (ds <= 5) seq.push_back({1'b0, S_D3});
         seq.push_back(E_RES);
      end
   endtask

   task automatic setResetExp();
      expStrobe = S_P1;
      expDone   = 1'b0;
      expPWin   = 1'b0;
      expDWin   = 1'b0;
   endtask

   // Plays one hand from reset; optionally pulls reset at sequence index abortIdx.
   task automatic applyStimulus(input int ps, input int ds, input int pc3,
                                input int psF, input int dsF, input int hold, input int abortIdx);
      buildSeq(ps, ds, pc3);
      resetb = 1'b0;
      pscore = 4'(ps);
      dscore = 4'(ds);
      pcard3 = 4'(pc3);
      setResetExp();
      checkEn = 1'b1;
      repeat (2) @(posedge slow_clock);
      @(negedge slow_clock);
      #2 resetb = 1'b1;
      for (int k = 1; k < seq.size(); k++) begin
         @(posedge slow_clock);
         #1;
         if (seq[k][6]) begin
            pscore    = 4'(psF);
            dscore    = 4'(dsF);
            expStrobe = 6'd0;
            expDone   = 1'b1;
            expPWin   = (psF >= dsF);
            expDWin   = (dsF >= psF);
         end else begin
            expStrobe = seq[k][5:0];
            expDone   = 1'b0;
            expPWin   = 1'b0;
            expDWin   = 1'b0;
         end
         if (k == abortIdx) begin
            #2 resetb = 1'b0;
            #1;
            checkOutput("abort_strobes",
                        {2'b0, load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1},
                        {2'b0, S_P1});
            checkOutput("abort_done", {7'b0, hand_done}, 8'd0);
            checkOutput("abort_lights", {6'b0, player_win_light, dealer_win_light}, 8'd0);
            setResetExp();
            @(posedge slow_clock);
            return;
         end
      end
      repeat (hold) @(posedge slow_clock);
      #1;
   endtask

   // Single comparator: all outputs against the model on every falling edge.
   always @(negedge slow_clock) begin
      if (checkEn) begin
         checkOutput("strobes",
                     {2'b0, load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1},
                     {2'b0, expStrobe});
         checkOutput("hand_done", {7'b0, hand_done}, {7'b0, expDone});
         checkOutput("player_win", {7'b0, player_win_light}, {7'b0, expPWin});
         checkOutput("dealer_win", {7'b0, dealer_win_light}, {7'b0, expDWin});
      end
   end

   initial begin
      int ps, ds, pc3, psF, dsF, ab;
      for (int d = 0; d < 10; d++) bankRow[d] = 10'h000;
      bankRow[0] = 10'h3FF;
      bankRow[1] = 10'h3FF;
      bankRow[2] = 10'h3FF;
      bankRow[3] = 10'h2FF;
      bankRow[4] = 10'h0FC;
      bankRow[5] = 10'h0F0;
      bankRow[6] = 10'h0C0;

      $display("[TB] start");

      // Hand lengths pinned by hand: 5, 6, 7, 8 edges.
      buildSeq(8, 3, 0);  checkOutput("len_natural", 8'(seq.size() - 1), 8'd5);
      buildSeq(7, 5, 0);  checkOutput("len_dealer_only", 8'(seq.size() - 1), 8'd6);
      buildSeq(3, 4, 12); checkOutput("len_player_only", 8'(seq.size() - 1), 8'd7);
      buildSeq(3, 4, 5);  checkOutput("len_both", 8'(seq.size() - 1), 8'd8);
      checkOutput("bank_6_7", {7'b0, bankerDraws(6, 7)}, 8'd1);
      checkOutput("bank_3_8", {7'b0, bankerDraws(3, 8)}, 8'd0);

      // Directed hands.
      applyStimulus(8, 3, 0, 8, 3, 2, -1);
      checkOutput("natural_pwin", {7'b0, player_win_light}, 8'd1);
      checkOutput("natural_dwin", {7'b0, dealer_win_light}, 8'd0);
      applyStimulus(7, 5, 0, 7, 9, 2, -1);
      checkOutput("dealer_pwin", {7'b0, player_win_light}, 8'd0);
      checkOutput("dealer_dwin", {7'b0, dealer_win_light}, 8'd1);
      applyStimulus(3, 4, 12, 3, 4, 1, -1);
      applyStimulus(3, 4, 5, 5, 2, 1, -1);
      applyStimulus(2, 6, 7, 9, 6, 1, -1);
      applyStimulus(2, 6, 8, 2, 6, 1, -1);
      applyStimulus(2, 3, 8, 4, 3, 1, -1);
      applyStimulus(2, 3, 9, 1, 3, 1, -1);
      applyStimulus(6, 6, 0, 6, 6, 10, -1);
      checkOutput("tie_both", {6'b0, player_win_light, dealer_win_light}, 8'd3);
      checkOutput("tie_done", {7'b0, hand_done}, 8'd1);
      applyStimulus(3, 4, 5, 3, 4, 0, 5);
      applyStimulus(3, 4, 5, 3, 4, 2, -1);

      // Random hands, some aborted by reset and then replayed.
      for (int n = 0; n < 40; n++) begin
         ps  = int'($urandom_range(0, 9));
         ds  = int'($urandom_range(0, 9));
         pc3 = int'($urandom_range(0, 13));
         psF = int'($urandom_range(0, 9));
         dsF = int'($urandom_range(0, 9));
         ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : -1;
         if (ab >= 0) applyStimulus(ps, ds, pc3, psF, dsF, 0, ab);
         applyStimulus(ps, ds, pc3, psF, dsF, int'($urandom_range(0, 3)), -1);
      end

      checkEn = 1'b0;
      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
